// File: rtl/alu_sched_pkg.sv
// Shared op codes, FSM states and op-shape helpers for the ALU request scheduler.
package alu_sched_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_BEGIN, S_LOAD1, S_LOAD2, S_LOAD3, S_WAIT, S_READ2, S_RESP
  } state_t;

  // Operand bytes streamed onto inbus: div needs a 16-bit dividend plus divisor.
  function automatic logic [1:0] load_count(input logic [1:0] op);
    logic [1:0] n;
    n = (op == OP_DIV) ? 2'd3 : 2'd2;
    return n;
  endfunction

  function automatic logic [1:0] result_count(input logic [1:0] op);
    logic [1:0] n;
    case (op)
      OP_ADD, OP_SUB: n = 2'd1;
      OP_MUL, OP_DIV: n = 2'd2;
      default:        n = 2'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner; pointer moves only on a grant.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 enable,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] index
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Walk offsets from farthest to nearest so the nearest requester overwrites.
  always_comb begin
    grant = '0;
    index = '0;
    for (int off = N; off >= 1; off--) begin
      if (req[wrap_idx(ptr, off)]) begin
        grant                     = '0;
        grant[wrap_idx(ptr, off)] = 1'b1;
        index                     = wrap_idx(ptr, off);
      end
    end
    if (!enable) grant = '0;
  end

  always_ff @(posedge clk) begin
    if (reset)                ptr <= IW'(N - 1);
    else if (enable && |req)  ptr <= index;
  end

endmodule

// File: rtl/alu_request_scheduler.sv
// Shares one ALU between N_REQ requesters: arbitrate, pulse BEGIN, stream operands,
// wait for END under a watchdog, then return the result bytes to the winner.
module alu_request_scheduler
  import alu_sched_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [2*N_REQ-1:0] req_op,
  input  logic [8*N_REQ-1:0] req_opa,
  input  logic [8*N_REQ-1:0] req_opb,
  input  logic [8*N_REQ-1:0] req_opc,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [7:0]         rsp_hi,
  output logic [7:0]         rsp_lo,
  output logic               rsp_err,
  output logic               busy,
  output logic               alu_begin,
  output logic [1:0]         alu_op_code,
  output logic [7:0]         alu_inbus,
  input  logic [7:0]         alu_outbus,
  input  logic               alu_end
);

  localparam int         IW  = $clog2(N_REQ);
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t state, nxt;

  logic [N_REQ-1:0][1:0] op_arr;
  logic [N_REQ-1:0][7:0] opa_arr, opb_arr, opc_arr;
  assign op_arr  = req_op;
  assign opa_arr = req_opa;
  assign opb_arr = req_opb;
  assign opc_arr = req_opc;

  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    gidx, g_q;
  logic [1:0]       op_q;
  logic [7:0]       a_q, b_q, c_q, cnt;
  logic             arb_en;

  // Gate with reset so nothing is accepted while the block is being cleared.
  assign arb_en = (state == S_IDLE) && !reset;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid),
    .enable (arb_en),
    .grant  (grant),
    .index  (gidx)
  );

  assign req_ready   = grant;
  assign alu_op_code = op_q;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt       = state;
    alu_begin = 1'b0;
    alu_inbus = '0;
    rsp_valid = '0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE:  if (|grant) nxt = S_BEGIN;
      S_BEGIN: begin
        alu_begin = 1'b1;
        nxt       = S_LOAD1;
      end
      S_LOAD1: begin
        alu_inbus = a_q;
        nxt       = S_LOAD2;
      end
      S_LOAD2: begin
        alu_inbus = b_q;
        nxt       = (load_count(op_q) == 2'd3) ? S_LOAD3 : S_WAIT;
      end
      S_LOAD3: begin
        alu_inbus = c_q;
        nxt       = S_WAIT;
      end
      // END beats the watchdog when both land in the same cycle.
      S_WAIT: begin
        if (alu_end)         nxt = (result_count(op_q) == 2'd2) ? S_READ2 : S_RESP;
        else if (cnt == TMO) nxt = S_RESP;
      end
      S_READ2: nxt = S_RESP;
      S_RESP: begin
        rsp_valid[g_q] = 1'b1;
        nxt            = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      g_q     <= '0;
      cnt     <= '0;
      rsp_hi  <= '0;
      rsp_lo  <= '0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (|grant) begin
          op_q    <= op_arr[gidx];
          a_q     <= opa_arr[gidx];
          b_q     <= opb_arr[gidx];
          c_q     <= opc_arr[gidx];
          g_q     <= gidx;
          cnt     <= '0;
          rsp_err <= 1'b0;
        end
        S_WAIT: begin
          if (alu_end) begin
            if (result_count(op_q) == 2'd1) begin
              rsp_lo <= alu_outbus;
              rsp_hi <= '0;
            end else begin
              rsp_hi <= alu_outbus;
            end
          end else if (cnt == TMO) begin
            rsp_err <= 1'b1;
            rsp_hi  <= '0;
            rsp_lo  <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_READ2: rsp_lo <= alu_outbus;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_request_scheduler.sv
// Randomized scoreboard bench for alu_request_scheduler with a behavioural ALU on the bus.
module tb_alu_request_scheduler;

  localparam int N     = 3;
  localparam int TO    = 4;
  localparam int NEVER = 99;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         rv;
  logic [N-1:0]         req_ready;
  logic [N-1:0][1:0]    rop;
  logic [N-1:0][7:0]    ra, rb, rc;
  logic [N-1:0]         rsp_valid;
  logic [7:0]           rsp_hi, rsp_lo;
  logic                 rsp_err, busy, alu_begin;
  logic [1:0]           alu_op_code;
  logic [7:0]           alu_inbus;
  logic [7:0]           alu_outbus;
  logic                 alu_end;

  alu_request_scheduler #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (rv),
    .req_ready   (req_ready),
    .req_op      (rop),
    .req_opa     (ra),
    .req_opb     (rb),
    .req_opc     (rc),
    .rsp_valid   (rsp_valid),
    .rsp_hi      (rsp_hi),
    .rsp_lo      (rsp_lo),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .alu_begin   (alu_begin),
    .alu_op_code (alu_op_code),
    .alu_inbus   (alu_inbus),
    .alu_outbus  (alu_outbus),
    .alu_end     (alu_end)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int idx; logic [1:0] op; logic [7:0] hi; logic [7:0] lo; logic err; } rsp_t;
  typedef struct { int acc; int dly; logic [1:0] op; logic [7:0] a; logic [7:0] b; logic [7:0] c; } job_t;

  rsp_t sbq[$];
  job_t aluq[$];
  int   tq[$];
  int   gseq[$];
  int   rdly[N];
  int   pct[N];

  // Expected response straight from the operation definitions.
  function automatic rsp_t ref_rsp(int idx, logic [1:0] op, logic [7:0] a, logic [7:0] b,
                                   logic [7:0] c, int dly);
    rsp_t r;
    logic [15:0] w;
    r.idx = idx; r.op = op; r.err = (dly == NEVER); r.hi = 8'h00; r.lo = 8'h00;
    if (!r.err) begin
      case (op)
        2'd0: r.lo = 8'(a + b);
        2'd1: r.lo = 8'(a - b);
        2'd2: begin w = a * b; r.hi = w[15:8]; r.lo = w[7:0]; end
        default: begin w = {a, b}; r.hi = 8'(w % c); r.lo = 8'(w / c); end
      endcase
    end
    return r;
  endfunction

  task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] c, input int dly);
    rv[i] = 1'b1; rop[i] = op; ra[i] = a; rb[i] = b; rc[i] = c; rdly[i] = dly;
  endtask

  task automatic new_req(input int i);
    logic [1:0] op;
    logic [7:0] c;
    op = 2'($urandom_range(3, 0));
    c  = 8'($urandom_range(255, 1));
    set_req(i, op, (op == 2'd3) ? 8'($urandom_range(int'(c) - 1, 0)) : 8'($urandom),
            8'($urandom), c, ($urandom_range(5, 0) == 5) ? NEVER : int'($urandom_range(4, 0)));
  endtask

  // One cycle of requester behaviour: note accepts at negedge, update after posedge.
  task automatic step();
    logic [N-1:0] acc;
    job_t j;
    @(negedge clk);
    acc = '0;
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        if (req_ready[i] && rv[i]) begin
          acc[i] = 1'b1;
          sbq.push_back(ref_rsp(i, rop[i], ra[i], rb[i], rc[i], rdly[i]));
          j.acc = cyc; j.dly = rdly[i]; j.op = rop[i]; j.a = ra[i]; j.b = rb[i]; j.c = rc[i];
          aluq.push_back(j);
          gseq.push_back(i);
        end
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) rv[i] = 1'b0;
      if (!rv[i] && int'($urandom_range(99, 0)) < pct[i]) new_req(i);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((rv != '0 || sbq.size() != 0 || busy) && n < 400);
    if (n >= 400) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},      busy,        0);
    chk({tag, "_begin"},     alu_begin,   0);
    chk({tag, "_op_code"},   alu_op_code, 0);
    chk({tag, "_inbus"},     alu_inbus,   0);
    chk({tag, "_rsp_hi"},    rsp_hi,      0);
    chk({tag, "_rsp_lo"},    rsp_lo,      0);
    chk({tag, "_rsp_err"},   rsp_err,     0);
    chk({tag, "_rsp_valid"}, rsp_valid,   0);
    chk({tag, "_req_ready"}, req_ready,   0);
  endtask

  task automatic do_reset();
    wait_idle();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    sbq.delete(); aluq.delete(); tq.delete();
  endtask

  // Behavioural ALU: checks BEGIN and the load bytes, answers after a per-job delay.
  initial begin
    int phase, nload, nb, wc, nres;
    job_t j;
    logic [7:0] bytes[3];
    logic [7:0] rhi, rlo, eb;
    logic [15:0] w;
    phase = 0; nload = 2; nb = 0; wc = 0; nres = 1; rhi = 0; rlo = 0;
    alu_end = 1'b0; alu_outbus = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        phase = 0;
      end else begin
        case (phase)
          0: begin
            chk("inbus_idle", alu_inbus, 0);
            if (alu_begin) begin
              if (aluq.size() == 0) chk("begin_unexpected", alu_begin, 0);
              else begin
                j = aluq.pop_front();
                chk("begin_latency", cyc, j.acc + 1);
                chk("begin_op", alu_op_code, j.op);
                nload = (j.op == 2'd3) ? 3 : 2;
                nb = 0;
                phase = 1;
              end
            end
          end
          1: begin
            eb = (nb == 0) ? j.a : (nb == 1) ? j.b : j.c;
            chk("load_byte", alu_inbus, eb);
            chk("op_held_load", alu_op_code, j.op);
            bytes[nb] = alu_inbus;
            nb++;
            if (nb == nload) begin phase = 2; wc = 0; end
          end
          default: begin
            chk("inbus_wait", alu_inbus, 0);
            chk("op_held_wait", alu_op_code, j.op);
          end
        endcase
      end
      @(posedge clk); #1;
      case (phase)
        2: begin
          if (j.dly != NEVER && wc == j.dly) begin
            nres = (j.op >= 2'd2) ? 2 : 1;
            rhi = 8'h00;
            case (j.op)
              2'd0: rlo = 8'(bytes[0] + bytes[1]);
              2'd1: rlo = 8'(bytes[0] - bytes[1]);
              2'd2: begin w = bytes[0] * bytes[1]; rhi = w[15:8]; rlo = w[7:0]; end
              default: begin w = {bytes[0], bytes[1]}; rhi = 8'(w % bytes[2]); rlo = 8'(w / bytes[2]); end
            endcase
            alu_end = 1'b1;
            alu_outbus = (nres == 2) ? rhi : rlo;
            tq.push_back(cyc + nres);
            phase = (nres == 2) ? 3 : 0;
          end else begin
            alu_end = 1'b0;
            alu_outbus = 8'($urandom);
            if (wc == 0 && j.dly == NEVER) tq.push_back(cyc + TO + 1);
            if (j.dly == NEVER && wc == TO) phase = 0;
            wc++;
          end
        end
        3: begin
          alu_end = 1'b0;
          alu_outbus = rlo;
          phase = 0;
        end
        default: begin
          alu_end = ($urandom_range(3, 0) == 0);
          alu_outbus = 8'($urandom);
        end
      endcase
    end
  end

  // Monitor: grant order, and responses popped from the scoreboard.
  initial begin
    int last, e, jj;
    bit prev_rsp;
    rsp_t r;
    last = N - 1; prev_rsp = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        last = N - 1;
        prev_rsp = 0;
      end else begin
        if (prev_rsp) chk("busy_after_rsp", busy, 0);
        prev_rsp = |rsp_valid;
        if (!busy && rv != '0) chk("accept_missing", |req_ready, 1);
        if (|req_ready) begin
          e = -1;
          for (int k = 1; k <= N; k++) begin
            jj = (last + k) % N;
            if (e < 0 && rv[jj]) e = jj;
          end
          if (e < 0) chk("grant_without_valid", req_ready, 0);
          else begin
            chk("grant", req_ready, 32'd1 << e);
            chk("busy_at_accept", busy, 0);
            last = e;
          end
        end
        if (|rsp_valid) begin
          if (sbq.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
          else begin
            r = sbq.pop_front();
            chk("rsp_valid_idx", rsp_valid, 32'd1 << r.idx);
            chk("rsp_hi", rsp_hi, r.hi);
            chk("rsp_lo", rsp_lo, r.lo);
            chk("rsp_err", rsp_err, r.err);
            chk("op_held_resp", alu_op_code, r.op);
            if (tq.size() == 0) chk("rsp_cycle_missing", 32'd0, 32'd1);
            else chk("rsp_cycle", cyc, tq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

  initial begin
    int n;
    rv = '0; rop = '0; ra = '0; rb = '0; rc = '0;
    for (int i = 0; i < N; i++) begin pct[i] = 0; rdly[i] = 0; end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("por");
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed: add, div sequencing, timeout, END on last watchdog cycles.
    set_req(0, 2'd0, 8'h12, 8'h34, 8'h00, 2);     wait_idle();
    set_req(0, 2'd3, 8'h00, 8'h64, 8'h07, 1);     wait_idle();
    set_req(1, 2'd2, 8'h0F, 8'h11, 8'h00, NEVER); wait_idle();
    set_req(2, 2'd1, 8'h10, 8'h20, 8'h00, 3);     wait_idle();
    set_req(0, 2'd2, 8'hFF, 8'hFF, 8'h00, 4);     wait_idle();
    set_req(1, 2'd0, 8'hFF, 8'h01, 8'h00, 0);     wait_idle();

    // Round robin with req0 and req1 always pending, straight after reset.
    do_reset();
    gseq.delete();
    pct[0] = 100; pct[1] = 100;
    n = 0;
    while (gseq.size() < 4 && n < 200) begin step(); n++; end
    pct[0] = 0; pct[1] = 0;
    wait_idle();
    if (gseq.size() < 4) chk("rr_grants", gseq.size(), 4);
    else for (int k = 0; k < 4; k++) chk("rr_sequence", gseq[k], k % 2);

    // Random traffic from all requesters.
    for (int i = 0; i < N; i++) pct[i] = 40;
    repeat (3000) step();
    for (int i = 0; i < N; i++) pct[i] = 0;
    wait_idle();

    // Reset during LOAD2; req1 waits and must be served afterwards.
    gseq.delete();
    set_req(0, 2'd3, 8'h01, 8'h02, 8'h09, 2);
    n = 0;
    while (gseq.size() == 0 && n < 50) begin step(); n++; end
    if (gseq.size() == 0) chk("midreset_accept", 32'd0, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    set_req(1, 2'd0, 8'h05, 8'h06, 8'h00, 1);
    @(posedge clk); #1;
    sbq.delete(); aluq.delete(); tq.delete();
    @(negedge clk);
    chk_reset_vals("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    gseq.delete();
    wait_idle();
    chk("midreset_req1_served", gseq.size(), 1);
    if (gseq.size() > 0) chk("midreset_req1_idx", gseq[0], 1);
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
